dmem_responder: RTL and testbench



---
 rtl/dmem_pkg.sv | 37 +++
 rtl/dmem_byte_array.sv | 31 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and helpers for the MEM-stage data responder.
// Transfer sizes are one-hot; a legal size's encoding equals its byte count.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] XFER_1B = 4'b0001;
    localparam logic [3:0] XFER_2B = 4'b0010;
    localparam logic [3:0] XFER_4B = 4'b0100;
    localparam logic [3:0] XFER_8B = 4'b1000;

    function automatic logic [3:0] xfer_bytes(input logic [3:0] xferSize);
        case (xferSize)
            XFER_1B: return 4'd1;
            XFER_2B: return 4'd2;
            XFER_4B: return 4'd4;
            XFER_8B: return 4'd8;
            default: return 4'd0;
        endcase
    endfunction

    // Only the three low address bits can break alignment for sizes up to 8 B.
    function automatic logic is_aligned(input logic [2:0] addr, input logic [3:0] size);
        case (size)
            XFER_1B: return 1'b1;
            XFER_2B: return addr[0] == 1'b0;
            XFER_4B: return addr[1:0] == 2'b00;
            XFER_8B: return addr[2:0] == 3'b000;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Byte-addressed little-endian storage: eight consecutive byte lanes from addr,
// written at the clock edge, read combinationally.
module dmem_byte_array #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [7:0]           byteEn,
    input  logic [63:0]          writeData,
    output logic [63:0]          readData
);

    logic [7:0] mem [2**ADDR_BITS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) begin
            if (byteEn[i]) begin
                mem[addr + ADDR_BITS'(i)] <= writeData[8*i +: 8];
            end
        end
    end

    // Lanes past the top of the array wrap; legal requests never use them.
    always_comb begin
        readData = '0;
        for (int i = 0; i < 8; i++) begin
            readData[8*i +: 8] = mem[addr + ADDR_BITS'(i)];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, serviced after
// WAIT_STATES wait cycles, completion signalled by a one-cycle ready pulse.
//
//   state | meaning
//   IDLE  | accepting requests; illegal ones pulse err and stay here
//   WAIT  | request latched; counter runs down, access on terminal count
//   DONE  | access performed; ready and busy high for this one cycle
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] address,
    input  logic        write_enable,
    input  logic        read_enable,
    input  logic [3:0]  xfer_size,
    input  logic [63:0] write_data,
    output logic [63:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        err
);

    state_t state, stateNext;
    logic [3:0] waitCnt;
    logic errNext, latchReq, decCnt, doAccess, illegal;

    logic [ADDR_BITS-1:0] addrQ;
    logic [3:0]  sizeQ;
    logic        writeQ;
    logic [63:0] wdataQ;
    logic [7:0]  byteEn;
    logic [63:0] arrayData, loadData;

    assign illegal = (write_enable && read_enable)
                  || !$onehot(xfer_size)
                  || !is_aligned(address[2:0], xfer_size)
                  || (address[63:ADDR_BITS] != '0);

    always_comb begin
        stateNext = state;
        errNext   = 1'b0;
        latchReq  = 1'b0;
        decCnt    = 1'b0;
        doAccess  = 1'b0;
        case (state)
            IDLE: begin
                if (write_enable || read_enable) begin
                    if (illegal) begin
                        errNext = 1'b1;
                    end else begin
                        latchReq  = 1'b1;
                        stateNext = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt == 4'd0) begin
                    doAccess  = 1'b1;
                    stateNext = DONE;
                end else begin
                    decCnt = 1'b1;
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            waitCnt   <= 4'd0;
            err       <= 1'b0;
            read_data <= '0;
        end else begin
            state <= stateNext;
            err   <= errNext;
            if (latchReq) begin
                waitCnt <= 4'(WAIT_STATES);
            end else if (decCnt) begin
                waitCnt <= waitCnt - 4'd1;
            end
            if (doAccess && !writeQ) begin
                read_data <= loadData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (latchReq) begin
            addrQ  <= address[ADDR_BITS-1:0];
            sizeQ  <= xfer_size;
            writeQ <= write_enable;
            wdataQ <= write_data;
        end
    end

    // Reset on the access edge must also suppress the store.
    always_comb begin
        byteEn   = '0;
        loadData = '0;
        for (int i = 0; i < 8; i++) begin
            byteEn[i] = doAccess && writeQ && !reset && (4'(i) < xfer_bytes(sizeQ));
            if (4'(i) < xfer_bytes(sizeQ)) begin
                loadData[8*i +: 8] = arrayData[8*i +: 8];
            end
        end
    end

    assign busy  = (state != IDLE);
    assign ready = (state == DONE);

    dmem_byte_array #(
        .ADDR_BITS(ADDR_BITS)
    ) u_array (
        .clk      (clk),
        .addr     (addrQ),
        .byteEn   (byteEn),
        .writeData(wdataQ),
        .readData (arrayData)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed and randomized checks of dmem_responder against a byte-array model,
// on three instances with WAIT_STATES = 2, 0 and 7.
module tb_dmem_responder;

    localparam int WSV [3] = '{2, 0, 7};

    logic clk = 1'b0;
    logic reset;
    logic [63:0] addr  [3];
    logic [63:0] wdata [3];
    logic [63:0] rdata [3];
    logic [3:0]  sz    [3];
    logic        we    [3];
    logic        re    [3];
    logic        rdy   [3];
    logic        bsy   [3];
    logic        er    [3];

    logic [7:0]  refMem [3][1024];
    logic [63:0] refRd  [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .ADDR_BITS  (10),
            .WAIT_STATES(WSV[g])
        ) dut (
            .clk         (clk),
            .reset       (reset),
            .address     (addr[g]),
            .write_enable(we[g]),
            .read_enable (re[g]),
            .xfer_size   (sz[g]),
            .write_data  (wdata[g]),
            .read_data   (rdata[g]),
            .ready       (rdy[g]),
            .busy        (bsy[g]),
            .err         (er[g])
        );
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic legal(input logic w, input logic r, input logic [63:0] a,
                                   input logic [3:0] s);
        if (w && r) return 1'b0;
        if ($countones(s) != 1) return 1'b0;
        if (a >= 64'd1024) return 1'b0;
        if ((a % 64'(s)) != 64'd0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [63:0] refLoad(input int u, input logic [63:0] a, input logic [3:0] s);
        logic [63:0] v = '0;
        for (int i = 0; i < int'(s); i++) begin
            v = v | (64'(refMem[u][int'(a[9:0]) + i]) << (8 * i));
        end
        return v;
    endfunction

    task automatic refStore(input int u, input logic [63:0] a, input logic [3:0] s, input logic [63:0] d);
        for (int i = 0; i < int'(s); i++) begin
            refMem[u][int'(a[9:0]) + i] = d[8*i +: 8];
        end
    endtask

    task automatic waitReady(input int u, input string tag, output int n);
        n = 1;
        while (rdy[u] !== 1'b1 && n < 40) begin
            check({tag, ":busy"}, 64'(bsy[u]), 64'd1);
            step();
            n++;
        end
        check({tag, ":ready"}, 64'(rdy[u]), 64'd1);
    endtask

    task automatic access(input int u, input logic w, input logic r, input logic [63:0] a,
                          input logic [3:0] s, input logic [63:0] d, input string tag);
        logic ok;
        int n;
        ok = legal(w, r, a, s);
        addr[u] = a; sz[u] = s; wdata[u] = d; we[u] = w; re[u] = r;
        step();
        if (!ok) begin
            check({tag, ":err"}, 64'(er[u]), 64'd1);
            check({tag, ":errbusy"}, 64'(bsy[u]), 64'd0);
            check({tag, ":errready"}, 64'(rdy[u]), 64'd0);
            we[u] = 1'b0; re[u] = 1'b0;
            step();
            check({tag, ":errpulse"}, 64'(er[u]), 64'd0);
            check({tag, ":errrd"}, rdata[u], refRd[u]);
        end else begin
            waitReady(u, tag, n);
            check({tag, ":latency"}, 64'(n), 64'(WSV[u] + 2));
            check({tag, ":noerr"}, 64'(er[u]), 64'd0);
            if (w) refStore(u, a, s, d);
            else   refRd[u] = refLoad(u, a, s);
            check({tag, ":rdata"}, rdata[u], refRd[u]);
            we[u] = 1'b0; re[u] = 1'b0;
            step();
            check({tag, ":idle"}, 64'({rdy[u], bsy[u]}), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [63:0] a;
        logic [3:0] s;
        logic w, r;

        reset = 1'b1;
        for (int u = 0; u < 3; u++) begin
            addr[u] = '0; wdata[u] = '0; sz[u] = 4'b0001; we[u] = 1'b0; re[u] = 1'b0;
            refRd[u] = '0;
        end
        step();
        step();
        for (int u = 0; u < 3; u++) begin
            check("reset:outs", 64'({rdy[u], bsy[u], er[u]}), 64'd0);
            check("reset:rdata", rdata[u], 64'd0);
        end
        reset = 1'b0;
        step();

        // store then load, 8 B
        access(0, 1, 0, 64'h10, 4'b1000, 64'h0123456789ABCDEF, "st8");
        access(0, 0, 1, 64'h10, 4'b1000, 64'h0, "ld8");
        check("ld8:const", rdata[0], 64'h0123456789ABCDEF);

        // byte lanes
        access(0, 1, 0, 64'h10, 4'b1000, 64'hFFFFFFFFFFFFFFFF, "ones");
        access(0, 1, 0, 64'h13, 4'b0001, 64'hAAAAAAAAAAAAAA5A, "st1");
        access(0, 0, 1, 64'h10, 4'b1000, 64'h0, "lane8");
        check("lane8:const", rdata[0], 64'hFFFFFFFF5AFFFFFF);
        access(0, 0, 1, 64'h13, 4'b0001, 64'h0, "lane1");
        check("lane1:const", rdata[0], 64'h000000000000005A);

        // errors
        access(0, 0, 1, 64'h12, 4'b1000, 64'h0, "unaligned");
        access(0, 0, 1, 64'h10, 4'b0011, 64'h0, "badsize");
        access(0, 1, 1, 64'h10, 4'b1000, 64'h0, "bothen");
        access(0, 0, 1, 64'h10, 4'b1000, 64'h0, "bothen:mem");
        check("bothen:const", rdata[0], 64'hFFFFFFFF5AFFFFFF);
        access(0, 0, 1, 64'h400, 4'b0001, 64'h0, "range");

        // latency on the WAIT_STATES = 0 and 7 instances
        for (int u = 1; u < 3; u++) begin
            access(u, 1, 0, 64'h40, 4'b0100, 64'h00000000CAFEF00D, "lat:st");
            access(u, 0, 1, 64'h40, 4'b0100, 64'h0, "lat:ld");
        end

        // randomized traffic over a preloaded window
        for (int i = 0; i < 16; i++) begin
            access(0, 1, 0, 64'(8 * i), 4'b1000, {$urandom, $urandom}, "pre");
        end
        for (int i = 0; i < 40; i++) begin
            a = 64'($urandom_range(0, 127));
            if ($urandom_range(0, 7) == 0) a = a + 64'h400;
            s = 4'(1 << $urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) s = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            r = !w;
            if ($urandom_range(0, 9) == 0) begin w = 1'b1; r = 1'b1; end
            access(0, w, r, a, s, {$urandom, $urandom}, "rand");
        end

        // back-to-back: enables held through ready
        addr[0] = 64'h18; sz[0] = 4'b1000; re[0] = 1'b1;
        step();
        waitReady(0, "b2b1", n);
        check("b2b1:latency", 64'(n), 64'd4);
        refRd[0] = refLoad(0, 64'h18, 4'b1000);
        check("b2b1:rdata", rdata[0], refRd[0]);
        step();
        check("b2b:gapidle", 64'({rdy[0], bsy[0]}), 64'd0);
        step();
        check("b2b2:taken", 64'(bsy[0]), 64'd1);
        re[0] = 1'b0;
        waitReady(0, "b2b2", n);
        check("b2b2:latency", 64'(n), 64'd4);
        check("b2b2:rdata", rdata[0], refRd[0]);
        step();

        // a request changed during WAIT has no effect
        addr[0] = 64'h30; sz[0] = 4'b0010; wdata[0] = 64'h1111; we[0] = 1'b1;
        step();
        addr[0] = 64'h38; sz[0] = 4'b0001; wdata[0] = 64'h22;
        waitReady(0, "midwait", n);
        check("midwait:latency", 64'(n), 64'd4);
        refStore(0, 64'h30, 4'b0010, 64'h1111);
        we[0] = 1'b0;
        step();
        access(0, 0, 1, 64'h30, 4'b1000, 64'h0, "midwait:ld30");
        access(0, 0, 1, 64'h38, 4'b1000, 64'h0, "midwait:ld38");

        // reset in the second WAIT cycle abandons the store
        addr[0] = 64'h20; sz[0] = 4'b0010; wdata[0] = 64'hDEAD; we[0] = 1'b1;
        step();
        step();
        check("rst:inwait", 64'(bsy[0]), 64'd1);
        reset = 1'b1; we[0] = 1'b0;
        step();
        check("rst:outs", 64'({rdy[0], bsy[0], er[0]}), 64'd0);
        check("rst:rdata", rdata[0], 64'd0);
        for (int u = 0; u < 3; u++) refRd[u] = '0;
        reset = 1'b0;
        step();
        access(0, 0, 1, 64'h20, 4'b0010, 64'h0, "rst:ld20");
        total++;
        assert (rdata[0] !== 64'hDEAD || refRd[0] === 64'hDEAD) else begin
            bad++;
            $error("FAIL rst:notwritten observed=%h expected=%h", rdata[0], refRd[0]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
